// File: rtl/gray_count_decoder.sv
// Gray-code receiver: registers an incoming Gray sample, decodes it to binary
// and classifies it against the previous accepted sample as +1, -1, hold or
// an illegal jump. Tracks a saturating error count and a lock indication.
module gray_count_decoder #(
  parameter int N        = 4,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     gray_in,
  input  logic             gray_valid,
  output logic [N-1:0]     bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   gray_s1;
  logic           valid_s1;
  logic [N-1:0]   bin_dec;
  logic [N-1:0]   prev_bin;
  logic [N-1:0]   diff;
  logic [7:0]     lock_cnt;
  logic           is_up;
  logic           is_down;
  logic           is_hold;

  // Each binary bit is the XOR of all Gray bits at or above its position;
  // writing it as a reduction avoids a ripple chain through bin_dec itself.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_decode
      assign bin_dec[gi] = ^gray_s1[N-1:gi];
    end
  endgenerate

  // Modular difference against the last accepted sample drives classification.
  assign diff    = bin_dec - prev_bin;
  assign is_up   = (diff == N'(1));
  assign is_down = (diff == {N{1'b1}});
  assign is_hold = (diff == '0);
  assign bin_out = prev_bin;

  // Stage 1: capture the raw Gray sample and its qualifier.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gray_s1  <= '0;
      valid_s1 <= 1'b0;
    end else begin
      gray_s1  <= gray_in;
      valid_s1 <= gray_valid;
    end
  end

  // Stage 2: decode, classify, run the lock FSM and register every output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= UNSYNC;
      prev_bin  <= '0;
      bin_valid <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      locked    <= 1'b0;
      lock_cnt  <= 8'd0;
    end else begin
      bin_valid <= valid_s1;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      err       <= 1'b0;
      if (valid_s1) begin
        // prev follows every accepted sample, errors included, so a single
        // glitch produces one error rather than a cascade.
        prev_bin <= bin_dec;
        case (state)
          UNSYNC: begin
            state    <= TRACK;
            lock_cnt <= 8'd0;
          end
          TRACK: begin
            if (is_up || is_down) begin
              step_up   <= is_up;
              step_down <= is_down;
              lock_cnt  <= lock_cnt + 8'd1;
              if (lock_cnt == 8'(LOCK_CNT - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (!is_hold) begin
              err      <= 1'b1;
              lock_cnt <= 8'd0;
              if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + ERR_W'(1);
              end
            end
          end
          LOCKED: begin
            if (is_up || is_down) begin
              step_up   <= is_up;
              step_down <= is_down;
            end else if (!is_hold) begin
              err      <= 1'b1;
              locked   <= 1'b0;
              lock_cnt <= 8'd0;
              state    <= TRACK;
              if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + ERR_W'(1);
              end
            end
          end
          default: begin
            state <= UNSYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed bench for gray_count_decoder: a vector table covering reset, the
// up-count to lock, reversal, wrap, hold, gaps and error/relock, followed by
// hand sequences for reset of an in-flight sample and counter saturation.
module tb_gray_count_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] gray_in = 4'd0;
  logic       gray_valid = 1'b0;

  logic [3:0] bin_out;
  logic       bin_valid, step_up, step_down, err, locked;
  logic [7:0] err_count;

  logic [3:0] bin_out2;
  logic       bin_valid2, step_up2, step_down2, err2, locked2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_count_decoder #(.N(4), .ERR_W(8), .LOCK_CNT(4)) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid),
    .bin_out(bin_out), .bin_valid(bin_valid), .step_up(step_up),
    .step_down(step_down), .err(err), .err_count(err_count), .locked(locked)
  );

  gray_count_decoder #(.N(4), .ERR_W(2), .LOCK_CNT(4)) dut2 (
    .clk(clk), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid),
    .bin_out(bin_out2), .bin_valid(bin_valid2), .step_up(step_up2),
    .step_down(step_down2), .err(err2), .err_count(err_count2), .locked(locked2)
  );

  // Row: inputs driven this cycle, and outputs expected just after the edge.
  // Outputs reflect the sample driven on the previous row.
  typedef struct packed {
    logic       rst;
    logic       gv;
    logic [3:0] g;
    logic       bv;
    logic [3:0] bin;
    logic       up;
    logic       dn;
    logic       er;
    logic [7:0] cnt;
    logic       lk;
  } vec_t;

  vec_t tbl [0:24];

  function automatic vec_t mk(logic rst, logic gv, logic [3:0] g, logic bv,
                              logic [3:0] bin, logic up, logic dn, logic er,
                              logic [7:0] cnt, logic lk);
    vec_t v;
    v.rst = rst; v.gv = gv; v.g = g; v.bv = bv; v.bin = bin;
    v.up = up; v.dn = dn; v.er = er; v.cnt = cnt; v.lk = lk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic gv, input logic [3:0] g);
    @(negedge clk);
    reset      = rst;
    gray_valid = gv;
    gray_in    = g;
    @(posedge clk);
    #1;
  endtask

  int sat;
  logic [3:0] err_pat [0:4];
  logic [3:0] pat_bin;

  initial begin
    //                rst gv  gray     bv  bin   up dn er cnt lk
    tbl[0]  = mk(1'b0, 1'b0, 4'b0000, 1'b0, 4'd0,  0, 0, 0, 8'd0, 0);
    tbl[1]  = mk(1'b0, 1'b0, 4'b0000, 1'b0, 4'd0,  0, 0, 0, 8'd0, 0);
    tbl[2]  = mk(1'b1, 1'b1, 4'b0000, 1'b0, 4'd0,  0, 0, 0, 8'd0, 0);
    tbl[3]  = mk(1'b1, 1'b1, 4'b0001, 1'b1, 4'd0,  0, 0, 0, 8'd0, 0);
    tbl[4]  = mk(1'b1, 1'b1, 4'b0011, 1'b1, 4'd1,  1, 0, 0, 8'd0, 0);
    tbl[5]  = mk(1'b1, 1'b1, 4'b0010, 1'b1, 4'd2,  1, 0, 0, 8'd0, 0);
    tbl[6]  = mk(1'b1, 1'b1, 4'b0110, 1'b1, 4'd3,  1, 0, 0, 8'd0, 0);
    tbl[7]  = mk(1'b1, 1'b1, 4'b0010, 1'b1, 4'd4,  1, 0, 0, 8'd0, 1);
    tbl[8]  = mk(1'b1, 1'b1, 4'b0011, 1'b1, 4'd3,  0, 1, 0, 8'd0, 1);
    tbl[9]  = mk(1'b1, 1'b0, 4'b0011, 1'b1, 4'd2,  0, 1, 0, 8'd0, 1);
    tbl[10] = mk(1'b1, 1'b1, 4'b0001, 1'b0, 4'd2,  0, 0, 0, 8'd0, 1);
    tbl[11] = mk(1'b1, 1'b1, 4'b0000, 1'b1, 4'd1,  0, 1, 0, 8'd0, 1);
    tbl[12] = mk(1'b1, 1'b1, 4'b1000, 1'b1, 4'd0,  0, 1, 0, 8'd0, 1);
    tbl[13] = mk(1'b1, 1'b1, 4'b0000, 1'b1, 4'd15, 0, 1, 0, 8'd0, 1);
    tbl[14] = mk(1'b1, 1'b1, 4'b1000, 1'b1, 4'd0,  1, 0, 0, 8'd0, 1);
    tbl[15] = mk(1'b1, 1'b1, 4'b1000, 1'b1, 4'd15, 0, 1, 0, 8'd0, 1);
    tbl[16] = mk(1'b1, 1'b1, 4'b0000, 1'b1, 4'd15, 0, 0, 0, 8'd0, 1);
    tbl[17] = mk(1'b1, 1'b1, 4'b0011, 1'b1, 4'd0,  1, 0, 0, 8'd0, 1);
    tbl[18] = mk(1'b1, 1'b1, 4'b0010, 1'b1, 4'd2,  0, 0, 1, 8'd1, 0);
    tbl[19] = mk(1'b1, 1'b1, 4'b0110, 1'b1, 4'd3,  1, 0, 0, 8'd1, 0);
    tbl[20] = mk(1'b1, 1'b1, 4'b0110, 1'b1, 4'd4,  1, 0, 0, 8'd1, 0);
    tbl[21] = mk(1'b1, 1'b1, 4'b0111, 1'b1, 4'd4,  0, 0, 0, 8'd1, 0);
    tbl[22] = mk(1'b1, 1'b1, 4'b0101, 1'b1, 4'd5,  1, 0, 0, 8'd1, 0);
    tbl[23] = mk(1'b1, 1'b0, 4'b0101, 1'b1, 4'd6,  1, 0, 0, 8'd1, 1);
    tbl[24] = mk(1'b1, 1'b0, 4'b0000, 1'b0, 4'd6,  0, 0, 0, 8'd1, 1);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].rst, tbl[i].gv, tbl[i].g);
      $display("vec %0d rst=%b gv=%b gray=%b -> bv=%b bin=%0d up=%b dn=%b err=%b cnt=%0d lk=%b",
               i, tbl[i].rst, tbl[i].gv, tbl[i].g, bin_valid, bin_out, step_up,
               step_down, err, err_count, locked);
      check($sformatf("vec%0d bin_valid", i), 32'(bin_valid), 32'(tbl[i].bv));
      check($sformatf("vec%0d bin_out", i),   32'(bin_out),   32'(tbl[i].bin));
      check($sformatf("vec%0d step_up", i),   32'(step_up),   32'(tbl[i].up));
      check($sformatf("vec%0d step_down", i), 32'(step_down), 32'(tbl[i].dn));
      check($sformatf("vec%0d err", i),       32'(err),       32'(tbl[i].er));
      check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d locked", i),    32'(locked),    32'(tbl[i].lk));
      sat = (tbl[i].cnt > 8'd3) ? 3 : int'(tbl[i].cnt);
      check($sformatf("vec%0d err_count_w2", i), 32'(err_count2), 32'(sat));
    end

    // Reset arriving while a sample sits in stage 1 must discard it.
    step(1'b1, 1'b1, 4'b0011);
    step(1'b0, 1'b0, 4'b0000);
    $display("rst-inflight: bv=%b bin=%0d cnt=%0d lk=%b", bin_valid, bin_out, err_count, locked);
    check("rst_inflight bin_valid", 32'(bin_valid), 32'd0);
    check("rst_inflight bin_out",   32'(bin_out),   32'd0);
    check("rst_inflight err_count", 32'(err_count), 32'd0);
    check("rst_inflight locked",    32'(locked),    32'd0);
    step(1'b1, 1'b0, 4'b0000);
    $display("post-reset idle: bv=%b", bin_valid);
    check("post_reset bin_valid", 32'(bin_valid), 32'd0);

    // First sample after reset is accepted in UNSYNC with no flags.
    step(1'b1, 1'b1, 4'b0110);
    step(1'b1, 1'b0, 4'b0000);
    $display("first sample: bv=%b bin=%0d up=%b dn=%b err=%b", bin_valid, bin_out,
             step_up, step_down, err);
    check("first bin_valid", 32'(bin_valid), 32'd1);
    check("first bin_out",   32'(bin_out),   32'd4);
    check("first flags",     32'({step_up, step_down, err}), 32'd0);

    // Five illegal jumps: 4->0->4->0->4->0; narrow counter saturates at 3.
    err_pat[0] = 4'b0000; err_pat[1] = 4'b0110; err_pat[2] = 4'b0000;
    err_pat[3] = 4'b0110; err_pat[4] = 4'b0000;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) step(1'b1, 1'b1, err_pat[i]);
      else       step(1'b1, 1'b0, 4'b0000);
      if (i >= 1) begin
        pat_bin = (err_pat[i-1] == 4'b0110) ? 4'd4 : 4'd0;
        $display("jump %0d: bv=%b err=%b bin=%0d cnt=%0d cnt_w2=%0d", i, bin_valid, err,
                 bin_out, err_count, err_count2);
        check($sformatf("jump%0d err", i),       32'(err),        32'd1);
        check($sformatf("jump%0d bin_out", i),   32'(bin_out),    32'(pat_bin));
        check($sformatf("jump%0d err_count", i), 32'(err_count),  32'(i));
        check($sformatf("jump%0d err_count_w2", i), 32'(err_count2), 32'((i > 3) ? 3 : i));
        check($sformatf("jump%0d locked", i),    32'(locked),     32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
